sigma_delta_dac_mc: RTL and testbench

SIGMA_DELTA_DAC_MC -- requirements
Module: sigma_delta_dac_mc

---
 rtl/sigma_delta_dac_mc.sv | 146 ++++++++++++++
 tb/tb_sigma_delta_dac_mc.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sigma_delta_dac_mc.sv
`timescale 1ns/1ps
// Multi-channel sigma-delta DAC: double-buffered per-channel codes swapped on a shared
// sample-period tick, feeding selectable first- or second-order 1-bit modulators.
module sigma_delta_dac_mc #(
  parameter int CODE_WIDTH = 10,
  parameter int NUM_CH     = 2,
  parameter int UPDATE_DIV = 256,
  localparam int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  code_valid,
  input  logic [CH_W-1:0]       code_ch,
  input  logic [CODE_WIDTH-1:0] code_data,
  output logic                  code_ready,
  input  logic                  mode,
  input  logic [NUM_CH-1:0]     ch_en,
  input  logic                  underrun_clr,
  output logic [NUM_CH-1:0]     underrun,
  output logic                  update_tick,
  output logic [NUM_CH-1:0]     pwm
);

  localparam int CNT_W = $clog2(UPDATE_DIV);
  localparam int IW    = CODE_WIDTH + 4;
  localparam int EW    = CODE_WIDTH + 6;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(UPDATE_DIV - 1);

  logic [CNT_W-1:0]                  cnt_q, cnt_d;
  logic                              tick_q, tick_d;
  logic                              mode_q, mode_chg, accept;
  logic [NUM_CH-1:0][CODE_WIDTH-1:0] pend_q, pend_d, act_q, act_d, acc_q, acc_d;
  logic [NUM_CH-1:0][IW-1:0]         i1_q, i1_d, i2_q, i2_d;
  logic [NUM_CH-1:0]                 full_q, full_d, unr_q, unr_d, pwm_q, pwm_d;
  logic [CODE_WIDTH:0]               sum;
  logic [EW-1:0]                     fb, t1, t2;
  logic [IW-1:0]                     i1n, i2n;

  // Clamp a wide two's-complement result into the integrator range.
  function automatic logic [IW-1:0] sat(input logic [EW-1:0] v);
    logic [EW-IW:0] top;
    top = v[EW-1:IW-1];
    if ((&top) || !(|top)) sat = v[IW-1:0];
    else if (v[EW-1])      sat = {1'b1, {(IW-1){1'b0}}};
    else                   sat = {1'b0, {(IW-1){1'b1}}};
  endfunction

  always_comb begin
    code_ready = 1'b0;
    if (int'(code_ch) < NUM_CH) code_ready = ~full_q[code_ch];
  end

  assign accept   = code_valid & code_ready;
  assign mode_chg = mode ^ mode_q;

  always_comb begin
    cnt_d  = (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
    tick_d = (cnt_d == CNT_LAST);
    pend_d = pend_q;
    full_d = full_q;
    act_d  = act_q;
    unr_d  = underrun_clr ? '0 : unr_q;
    for (int n = 0; n < NUM_CH; n++) begin
      if (tick_q) begin
        if (full_q[n]) begin
          act_d[n]  = pend_q[n];
          full_d[n] = 1'b0;
        end else begin
          unr_d[n] = 1'b1;
        end
      end
      // A write landing on a tick only fills pending; it waits for the next tick.
      if (accept && (code_ch == CH_W'(n))) begin
        pend_d[n] = code_data;
        full_d[n] = 1'b1;
      end
    end
  end

  always_comb begin
    acc_d = acc_q;
    i1_d  = i1_q;
    i2_d  = i2_q;
    pwm_d = pwm_q;
    sum   = '0;
    fb    = '0;
    t1    = '0;
    t2    = '0;
    i1n   = '0;
    i2n   = '0;
    for (int n = 0; n < NUM_CH; n++) begin
      if (mode_chg || !ch_en[n]) begin
        acc_d[n] = '0;
        i1_d[n]  = '0;
        i2_d[n]  = '0;
        pwm_d[n] = 1'b0;
      end else if (!mode_q) begin
        sum      = {1'b0, acc_q[n]} + {1'b0, act_q[n]};
        acc_d[n] = sum[CODE_WIDTH-1:0];
        pwm_d[n] = sum[CODE_WIDTH];
      end else begin
        fb  = {{(EW-CODE_WIDTH-1){1'b0}}, pwm_q[n], {CODE_WIDTH{1'b0}}};
        t1  = {{(EW-IW){i1_q[n][IW-1]}}, i1_q[n]} + {{(EW-CODE_WIDTH){1'b0}}, act_q[n]} - fb;
        i1n = sat(t1);
        t2  = {{(EW-IW){i2_q[n][IW-1]}}, i2_q[n]} + {{(EW-IW){i1n[IW-1]}}, i1n} - fb;
        i2n = sat(t2);
        i1_d[n]  = i1n;
        i2_d[n]  = i2n;
        pwm_d[n] = ~i2n[IW-1];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
      mode_q <= 1'b0;
      pend_q <= '0;
      full_q <= '0;
      act_q  <= '0;
      acc_q  <= '0;
      i1_q   <= '0;
      i2_q   <= '0;
      unr_q  <= '0;
      pwm_q  <= '0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
      mode_q <= mode;
      pend_q <= pend_d;
      full_q <= full_d;
      act_q  <= act_d;
      acc_q  <= acc_d;
      i1_q   <= i1_d;
      i2_q   <= i2_d;
      unr_q  <= unr_d;
      pwm_q  <= pwm_d;
    end
  end

  assign underrun    = unr_q;
  assign update_tick = tick_q;
  assign pwm         = pwm_q;

endmodule

// File: tb/tb_sigma_delta_dac_mc.sv
`timescale 1ns/1ps
// Self-checking bench for sigma_delta_dac_mc: directed scenarios plus a randomized run,
// all compared against an integer-arithmetic model of the DAC.
module tb_sigma_delta_dac_mc;

  localparam int CW   = 10;
  localparam int NCH  = 2;
  localparam int DIV  = 32;
  localparam int CH_W = 1;
  localparam int FULL = 1 << CW;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            code_valid = 1'b0;
  logic [CH_W-1:0] code_ch = '0;
  logic [CW-1:0]   code_data = '0;
  logic            mode = 1'b0;
  logic [NCH-1:0]  ch_en = '1;
  logic            underrun_clr = 1'b0;
  logic            code_ready;
  logic [NCH-1:0]  underrun;
  logic            update_tick;
  logic [NCH-1:0]  pwm;

  int compared = 0;
  int mismatched = 0;

  sigma_delta_dac_mc #(.CODE_WIDTH(CW), .NUM_CH(NCH), .UPDATE_DIV(DIV)) dut (
    .clk(clk), .rst_n(rst_n), .code_valid(code_valid), .code_ch(code_ch),
    .code_data(code_data), .code_ready(code_ready), .mode(mode), .ch_en(ch_en),
    .underrun_clr(underrun_clr), .underrun(underrun), .update_tick(update_tick), .pwm(pwm)
  );

  always #5 clk = ~clk;

  // Reference model: cycles since reset decide the tick; modulators in plain integers.
  int  mCnt, mPend[NCH], mAct[NCH], mAcc[NCH], mI1[NCH], mI2[NCH];
  bit  mTick, mMode, mFull[NCH], mUnr[NCH], mPwm[NCH];
  int  s, fbv;
  bit  take;

  function automatic int clampI(input int v);
    int hi = (1 << (CW + 3)) - 1;
    int lo = -(1 << (CW + 3));
    return (v > hi) ? hi : ((v < lo) ? lo : v);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mCnt = 0; mTick = 0; mMode = 0;
      for (int n = 0; n < NCH; n++) begin
        mPend[n] = 0; mAct[n] = 0; mAcc[n] = 0; mI1[n] = 0; mI2[n] = 0;
        mFull[n] = 0; mUnr[n] = 0; mPwm[n] = 0;
      end
    end else begin
      take = code_valid && (int'(code_ch) < NCH) && !mFull[code_ch];
      for (int n = 0; n < NCH; n++) begin
        if ((mode != mMode) || !ch_en[n]) begin
          mAcc[n] = 0; mI1[n] = 0; mI2[n] = 0; mPwm[n] = 0;
        end else if (!mMode) begin
          s = mAcc[n] + mAct[n];
          mPwm[n] = (s >= FULL);
          mAcc[n] = s % FULL;
        end else begin
          fbv = mPwm[n] ? FULL : 0;
          mI1[n] = clampI(mI1[n] + mAct[n] - fbv);
          mI2[n] = clampI(mI2[n] + mI1[n] - fbv);
          mPwm[n] = (mI2[n] >= 0);
        end
      end
      mMode = mode;
      if (underrun_clr) for (int n = 0; n < NCH; n++) mUnr[n] = 0;
      if (mTick) begin
        for (int n = 0; n < NCH; n++) begin
          if (mFull[n]) begin mAct[n] = mPend[n]; mFull[n] = 0; end
          else mUnr[n] = 1;
        end
      end
      if (take) begin mPend[code_ch] = int'(code_data); mFull[code_ch] = 1; end
      mCnt = (mCnt + 1) % DIV;
      mTick = (mCnt == DIV - 1);
    end
  end

  function automatic logic [NCH-1:0] modelPwm();
    for (int n = 0; n < NCH; n++) modelPwm[n] = mPwm[n];
  endfunction

  function automatic logic [NCH-1:0] modelUnr();
    for (int n = 0; n < NCH; n++) modelUnr[n] = mUnr[n];
  endfunction

  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic v, input int ch, input int d);
    code_valid = v;
    code_ch    = CH_W'(ch);
    code_data  = CW'(d);
  endtask

  task automatic waitForTick(output bit seen);
    for (int k = 0; k < 2 * DIV && !update_tick; k++) stepCycle();
    seen = update_tick;
  endtask

  task automatic test_reset();
    int edges;
    rst_n = 1'b0; ch_en = '1; mode = 1'b0;
    applyStimulus(0, 0, 0);
    repeat (3) stepCycle();
    compared++; if (pwm !== '0) begin mismatched++; $display("[TB] FAIL reset_pwm: got %b expected 00", pwm); end
    compared++; if (underrun !== '0) begin mismatched++; $display("[TB] FAIL reset_underrun: got %b expected 00", underrun); end
    compared++; if (update_tick !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_tick: got %b expected 0", update_tick); end
    for (int c = 0; c < NCH; c++) begin
      code_ch = CH_W'(c); #1;
      compared++; if (code_ready !== 1'b1) begin mismatched++; $display("[TB] FAIL reset_ready ch%0d: got %b expected 1", c, code_ready); end
    end
    rst_n = 1'b1;
    edges = 0;
    while (!update_tick && edges < 2 * DIV) begin stepCycle(); edges++; end
    compared++; if (edges != DIV - 1) begin mismatched++; $display("[TB] FAIL first_tick_edges: got %0d expected %0d", edges, DIV - 1); end
    stepCycle();
    compared++; if (update_tick !== 1'b0) begin mismatched++; $display("[TB] FAIL tick_width: got %b expected 0", update_tick); end
    edges = 1;
    while (!update_tick && edges < 2 * DIV) begin stepCycle(); edges++; end
    compared++; if (edges != DIV) begin mismatched++; $display("[TB] FAIL tick_period: got %0d expected %0d", edges, DIV); end
  endtask

  task automatic test_underrun();
    bit seen;
    stepCycle();
    compared++; if (underrun !== 2'b11) begin mismatched++; $display("[TB] FAIL underrun_set: got %b expected 11", underrun); end
    underrun_clr = 1'b1; stepCycle(); underrun_clr = 1'b0;
    compared++; if (underrun !== 2'b00) begin mismatched++; $display("[TB] FAIL underrun_clear: got %b expected 00", underrun); end
    waitForTick(seen);
    compared++; if (!seen) begin mismatched++; $display("[TB] FAIL underrun_tick_wait: got timeout expected tick"); end
    underrun_clr = 1'b1; stepCycle(); underrun_clr = 1'b0;
    compared++; if (underrun !== 2'b11) begin mismatched++; $display("[TB] FAIL underrun_set_over_clr: got %b expected 11", underrun); end
    underrun_clr = 1'b1; stepCycle(); underrun_clr = 1'b0;
  endtask

  task automatic test_first_order();
    bit seen;
    int ones0, ones1;
    code_ch = '0; #1;
    compared++; if (code_ready !== 1'b1) begin mismatched++; $display("[TB] FAIL fo_ready: got %b expected 1", code_ready); end
    applyStimulus(1, 0, 256); stepCycle(); applyStimulus(0, 0, 0);
    waitForTick(seen);
    compared++; if (!seen) begin mismatched++; $display("[TB] FAIL fo_tick_wait: got timeout expected tick"); end
    for (int i = 1; i <= 5; i++) begin
      stepCycle();
      compared++;
      if (pwm[0] !== (i == 5)) begin mismatched++; $display("[TB] FAIL fo_first_pulse cycle %0d: got %b expected %b", i, pwm[0], (i == 5)); end
    end
    ones0 = 0; ones1 = 0;
    repeat (1024) begin
      stepCycle();
      ones0 += int'(pwm[0]); ones1 += int'(pwm[1]);
      compared++; if (pwm !== modelPwm()) begin mismatched++; $display("[TB] FAIL fo_model_pwm: got %b expected %b", pwm, modelPwm()); end
    end
    compared++; if (ones0 != 256) begin mismatched++; $display("[TB] FAIL fo_duty_256: got %0d expected 256", ones0); end
    compared++; if (ones1 != 0) begin mismatched++; $display("[TB] FAIL fo_ch1_idle: got %0d expected 0", ones1); end
  endtask

  task automatic test_back_to_back();
    bit seen;
    int ones0, ones1;
    stepCycle(); waitForTick(seen); stepCycle();
    code_ch = CH_W'(1); #1;
    compared++; if (code_ready !== 1'b1) begin mismatched++; $display("[TB] FAIL b2b_first_ready: got %b expected 1", code_ready); end
    applyStimulus(1, 1, 700); stepCycle();
    applyStimulus(1, 1, 100); #1;
    compared++; if (code_ready !== 1'b0) begin mismatched++; $display("[TB] FAIL b2b_second_ready: got %b expected 0", code_ready); end
    stepCycle(); applyStimulus(0, 1, 0); #1;
    compared++; if (code_ready !== 1'b0) begin mismatched++; $display("[TB] FAIL b2b_held_ready: got %b expected 0", code_ready); end
    waitForTick(seen);
    compared++; if (!seen) begin mismatched++; $display("[TB] FAIL b2b_tick_wait: got timeout expected tick"); end
    stepCycle();
    compared++; if (code_ready !== 1'b1) begin mismatched++; $display("[TB] FAIL b2b_ready_after_tick: got %b expected 1", code_ready); end
    ones0 = 0; ones1 = 0;
    repeat (1024) begin
      stepCycle();
      ones0 += int'(pwm[0]); ones1 += int'(pwm[1]);
      compared++; if (pwm !== modelPwm()) begin mismatched++; $display("[TB] FAIL b2b_model_pwm: got %b expected %b", pwm, modelPwm()); end
    end
    compared++; if (ones1 != 700) begin mismatched++; $display("[TB] FAIL b2b_ch1_duty: got %0d expected 700", ones1); end
    compared++; if (ones0 != 256) begin mismatched++; $display("[TB] FAIL b2b_ch0_duty: got %0d expected 256", ones0); end
  endtask

  task automatic test_second_order();
    bit seen;
    int ones;
    stepCycle(); waitForTick(seen); stepCycle();
    applyStimulus(1, 0, 512); stepCycle(); applyStimulus(0, 0, 0);
    waitForTick(seen);
    compared++; if (!seen) begin mismatched++; $display("[TB] FAIL so_tick_wait: got timeout expected tick"); end
    stepCycle();
    mode = 1'b1; stepCycle();
    compared++; if (pwm !== 2'b00) begin mismatched++; $display("[TB] FAIL so_mode_clear: got %b expected 00", pwm); end
    ones = 0;
    repeat (8192) begin
      stepCycle();
      ones += int'(pwm[0]);
      compared++; if (pwm !== modelPwm()) begin mismatched++; $display("[TB] FAIL so_model_pwm: got %b expected %b", pwm, modelPwm()); end
    end
    compared++; if (ones < 4096 - 8 || ones > 4096 + 8) begin mismatched++; $display("[TB] FAIL so_duty_half: got %0d expected 4088..4104", ones); end
    mode = 1'b0; stepCycle();
    compared++; if (pwm !== 2'b00) begin mismatched++; $display("[TB] FAIL so_mode_back_clear: got %b expected 00", pwm); end
    repeat (64) begin
      stepCycle();
      compared++; if (pwm !== modelPwm()) begin mismatched++; $display("[TB] FAIL so_back_model_pwm: got %b expected %b", pwm, modelPwm()); end
    end
  endtask

  task automatic test_channel_enable();
    bit seen;
    int hiCount;
    stepCycle(); waitForTick(seen); stepCycle();
    applyStimulus(1, 0, 1023); stepCycle(); applyStimulus(0, 0, 0);
    waitForTick(seen);
    compared++; if (!seen) begin mismatched++; $display("[TB] FAIL en_tick_wait: got timeout expected tick"); end
    repeat (9) stepCycle();
    ch_en = 2'b10; stepCycle();
    hiCount = 0;
    repeat (100) begin
      stepCycle();
      hiCount += int'(pwm[0]);
      compared++; if (pwm !== modelPwm()) begin mismatched++; $display("[TB] FAIL en_model_pwm: got %b expected %b", pwm, modelPwm()); end
    end
    compared++; if (hiCount != 0) begin mismatched++; $display("[TB] FAIL en_disabled_pwm: got %0d high cycles expected 0", hiCount); end
    ch_en = '1; stepCycle();
    compared++; if (pwm[0] !== 1'b0) begin mismatched++; $display("[TB] FAIL en_restart_c1: got %b expected 0", pwm[0]); end
    stepCycle();
    compared++; if (pwm[0] !== 1'b1) begin mismatched++; $display("[TB] FAIL en_restart_c2: got %b expected 1", pwm[0]); end
  endtask

  task automatic test_random();
    for (int c = 0; c < 1500; c++) begin
      stepCycle();
      compared++; if (pwm !== modelPwm()) begin mismatched++; $display("[TB] FAIL rnd_pwm c%0d: got %b expected %b", c, pwm, modelPwm()); end
      compared++; if (underrun !== modelUnr()) begin mismatched++; $display("[TB] FAIL rnd_underrun c%0d: got %b expected %b", c, underrun, modelUnr()); end
      compared++; if (update_tick !== mTick) begin mismatched++; $display("[TB] FAIL rnd_tick c%0d: got %b expected %b", c, update_tick, mTick); end
      code_valid   = ($urandom_range(0, 3) == 0);
      code_ch      = CH_W'($urandom_range(0, NCH - 1));
      code_data    = CW'($urandom);
      underrun_clr = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 63) == 0) ch_en = NCH'($urandom);
      if ($urandom_range(0, 199) == 0) mode = ~mode;
      #1;
      compared++;
      if (code_ready !== ((int'(code_ch) < NCH) && !mFull[code_ch])) begin
        mismatched++; $display("[TB] FAIL rnd_ready c%0d: got %b expected %b", c, code_ready, !mFull[code_ch]);
      end
    end
    applyStimulus(0, 0, 0);
    underrun_clr = 1'b0; ch_en = '1; mode = 1'b0;
  endtask

  task automatic test_reset_mid();
    bit seen;
    int edges, hiCount;
    stepCycle(); waitForTick(seen); stepCycle();
    repeat (5) stepCycle();
    applyStimulus(1, 0, 300); stepCycle();
    applyStimulus(1, 1, 600); stepCycle();
    applyStimulus(0, 0, 0); #1;
    compared++; if (code_ready !== 1'b0) begin mismatched++; $display("[TB] FAIL rm_pending_full: got %b expected 0", code_ready); end
    rst_n = 1'b0; #1;
    compared++; if (pwm !== '0) begin mismatched++; $display("[TB] FAIL rm_pwm: got %b expected 00", pwm); end
    compared++; if (underrun !== '0) begin mismatched++; $display("[TB] FAIL rm_underrun: got %b expected 00", underrun); end
    compared++; if (update_tick !== 1'b0) begin mismatched++; $display("[TB] FAIL rm_tick: got %b expected 0", update_tick); end
    compared++; if (code_ready !== 1'b1) begin mismatched++; $display("[TB] FAIL rm_ready ch0: got %b expected 1", code_ready); end
    code_ch = CH_W'(1); #1;
    compared++; if (code_ready !== 1'b1) begin mismatched++; $display("[TB] FAIL rm_ready ch1: got %b expected 1", code_ready); end
    repeat (2) stepCycle();
    rst_n = 1'b1;
    edges = 0;
    while (!update_tick && edges < 2 * DIV) begin stepCycle(); edges++; end
    compared++; if (edges != DIV - 1) begin mismatched++; $display("[TB] FAIL rm_tick_edges: got %0d expected %0d", edges, DIV - 1); end
    stepCycle();
    compared++; if (underrun !== 2'b11) begin mismatched++; $display("[TB] FAIL rm_pending_discarded: got %b expected 11", underrun); end
    hiCount = 0;
    repeat (40) begin stepCycle(); hiCount += int'(pwm[0]) + int'(pwm[1]); end
    compared++; if (hiCount != 0) begin mismatched++; $display("[TB] FAIL rm_active_cleared: got %0d high samples expected 0", hiCount); end
  endtask

  initial begin
    test_reset();
    test_underrun();
    test_first_order();
    test_back_to_back();
    test_second_order();
    test_channel_enable();
    test_random();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
